// File: rtl/reconfig_pkg.sv
// -----------------------------------------------------------------------------
// reconfig_pkg
// Shared types and default constants for the remote-reconfiguration controller.
//   state_t          : controller FSM states
//   DEF_TIMEOUT      : default auto-reconfiguration terminal count (~7 s)
//   DEF_SETUP_CYC    : default cfg_CBSEL setup time before cfg_CONFIG rises
//   ARM_CNT_W        : width of the ARM-phase cycle counter (SETUP_CYC <= 15)
// -----------------------------------------------------------------------------
package reconfig_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      COUNT = 3'd1,
      ARM   = 3'd2,
      FIRE  = 3'd3,
      ERR   = 3'd4
   } state_t;

   localparam logic [23:0] DEF_TIMEOUT   = 24'h1AB3FF;
   localparam int unsigned DEF_SETUP_CYC = 2;
   localparam int unsigned ARM_CNT_W     = 4;

endpackage

// File: rtl/reconfig_timer.sv
// -----------------------------------------------------------------------------
// reconfig_timer
// Saturating up-counter used as the auto-reconfiguration timer. It counts while
// en is high, holds at TIMEOUT once reached, and returns to zero on clr.
// Ports:
//   clk    : clock, rising edge
//   rstn   : asynchronous active-low reset
//   clr    : synchronous clear (wins over en)
//   en     : count enable
//   expire : high while the count equals TIMEOUT
// -----------------------------------------------------------------------------
module reconfig_timer
   import reconfig_pkg::*;
#(
   parameter int unsigned      CNT_W   = 24,
   parameter logic [CNT_W-1:0] TIMEOUT = CNT_W'(DEF_TIMEOUT)
) (
   input  logic clk,
   input  logic rstn,
   input  logic clr,
   input  logic en,
   output logic expire
);

   logic [CNT_W-1:0] cnt;

   // Increment that sticks at the terminal count instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v >= TIMEOUT) ? v : v + 1'b1;
   endfunction

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= sat_inc(cnt);
      end
   end

   assign expire = (cnt == TIMEOUT);

endmodule

// File: rtl/reconfig_ctrl.sv
// -----------------------------------------------------------------------------
// reconfig_ctrl
// Drives the FPGA remote-update block: selects an image on cfg_CBSEL, holds it
// stable for SETUP_CYC cycles, then raises cfg_CONFIG. A reconfiguration is
// started either by a user request (req/req_img) or by the auto timer expiring
// (AUTO_IMG). A device error while firing is latched in err_sticky.
// Optional feature: define RECONFIG_RETRY_EN to retry once with FALLBACK_IMG
// after the first error of a trigger.
// Ports:
//   clk, rstn        : clock (rising edge), asynchronous active-low reset
//   auto_en          : enables timer-driven reconfiguration
//   req, req_img     : single-cycle user request and its image
//   cfg_ERROR        : error flag from the configuration block
//   cfg_CBSEL        : image select (registered)
//   cfg_ENA          : reconfiguration enable, high from the first edge after reset
//   cfg_CONFIG       : reconfiguration trigger (registered)
//   cfg_ERROR_port   : cfg_ERROR passed straight through
//   busy             : high in ARM, FIRE and ERR
//   err_sticky       : latched reconfiguration failure
// -----------------------------------------------------------------------------
module reconfig_ctrl
   import reconfig_pkg::*;
#(
   parameter int unsigned      CNT_W        = 24,
   parameter logic [CNT_W-1:0] TIMEOUT      = CNT_W'(DEF_TIMEOUT),
   parameter int unsigned      SEL_W        = 2,
   parameter logic [SEL_W-1:0] AUTO_IMG     = '0,
   parameter logic [SEL_W-1:0] FALLBACK_IMG = '0,
   parameter int unsigned      SETUP_CYC    = DEF_SETUP_CYC   // 1..15
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             auto_en,
   input  logic             req,
   input  logic [SEL_W-1:0] req_img,
   input  logic             cfg_ERROR,
   output logic [SEL_W-1:0] cfg_CBSEL,
   output logic             cfg_ENA,
   output logic             cfg_CONFIG,
   output logic             cfg_ERROR_port,
   output logic             busy,
   output logic             err_sticky
);

   localparam logic [ARM_CNT_W-1:0] ARM_LAST = ARM_CNT_W'(SETUP_CYC - 1);

   state_t                 state;
   logic [ARM_CNT_W-1:0]   arm_cnt;
   logic                   tmr_clr;
   logic                   tmr_en;
   logic                   tmr_expire;
   logic                   req_acc;
   logic                   auto_fire;
   logic                   trig;
   logic [SEL_W-1:0]       trig_img;
`ifdef RECONFIG_RETRY_EN
   logic                   retried;
`endif

   assign cfg_ERROR_port = cfg_ERROR;

   // cfg_ENA doubles as the "out of reset for one edge" flag, so no state can
   // change on the first edge after reset release.
   assign req_acc   = cfg_ENA && req && ((state == IDLE) || (state == COUNT));
   // A request in the same cycle discards the timer path.
   assign auto_fire = (state == COUNT) && auto_en && tmr_expire && !req;
   assign trig      = req_acc || auto_fire;
   assign trig_img  = req_acc ? req_img : AUTO_IMG;

   assign tmr_en  = (state == COUNT);
   assign tmr_clr = (state != COUNT) || !auto_en || req;

   reconfig_timer #(
      .CNT_W   (CNT_W),
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .clk    (clk),
      .rstn   (rstn),
      .clr    (tmr_clr),
      .en     (tmr_en),
      .expire (tmr_expire)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state      <= IDLE;
         arm_cnt    <= '0;
         cfg_CBSEL  <= AUTO_IMG;
         cfg_ENA    <= 1'b0;
         cfg_CONFIG <= 1'b0;
         busy       <= 1'b0;
         err_sticky <= 1'b0;
`ifdef RECONFIG_RETRY_EN
         retried    <= 1'b0;
`endif
      end else begin
         cfg_ENA <= 1'b1;
         if (cfg_ENA) begin
            case (state)
               IDLE, COUNT: begin
                  if (trig) begin
                     cfg_CBSEL  <= trig_img;
                     err_sticky <= 1'b0;
                     arm_cnt    <= '0;
                     busy       <= 1'b1;
                     state      <= ARM;
`ifdef RECONFIG_RETRY_EN
                     retried    <= 1'b0;
`endif
                  end else if ((state == IDLE) && auto_en) begin
                     state <= COUNT;
                  end else if ((state == COUNT) && !auto_en) begin
                     state <= IDLE;
                  end
               end
               ARM: begin
                  if (arm_cnt == ARM_LAST) begin
                     cfg_CONFIG <= 1'b1;
                     state      <= FIRE;
                  end else begin
                     arm_cnt <= arm_cnt + 1'b1;
                  end
               end
               FIRE: begin
                  // Without an error the device reload ends operation here.
                  if (cfg_ERROR) begin
                     cfg_CONFIG <= 1'b0;
                     err_sticky <= 1'b1;
                     state      <= ERR;
                  end
               end
               ERR: begin
`ifdef RECONFIG_RETRY_EN
                  if (!retried && (cfg_CBSEL != FALLBACK_IMG)) begin
                     retried   <= 1'b1;
                     cfg_CBSEL <= FALLBACK_IMG;
                     arm_cnt   <= '0;
                     state     <= ARM;
                  end else begin
                     busy  <= 1'b0;
                     state <= IDLE;
                  end
`else
                  busy  <= 1'b0;
                  state <= IDLE;
`endif
               end
               default: begin
                  cfg_CONFIG <= 1'b0;
                  busy       <= 1'b0;
                  state      <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_reconfig_ctrl.sv
// -----------------------------------------------------------------------------
// tb_reconfig_ctrl
// Directed sequence followed by randomized traffic, every cycle compared with a
// behavioural model of the controller kept in this file.
// Honours RECONFIG_RETRY_EN when the design is built with it.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_reconfig_ctrl;

   localparam int         TMO          = 10;
   localparam int         SETUP_CYC    = 2;
   localparam logic [1:0] AUTO_IMG     = 2'b11;
   localparam logic [1:0] FALLBACK_IMG = 2'b00;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic       auto_en = 1'b0;
   logic       req = 1'b0;
   logic [1:0] req_img = 2'b00;
   logic       cfg_ERROR = 1'b0;
   logic [1:0] cfg_CBSEL;
   logic       cfg_ENA, cfg_CONFIG, cfg_ERROR_port, busy, err_sticky;

   int n_cmp = 0;
   int n_bad = 0;

   // Behavioural model: out-of-reset flag, busy flag, phase countdown and
   // a plain integer timer.
   bit         m_ena, m_busy, m_cfg, m_sticky, m_counting, m_retry;
   int         m_timer, m_arm_left;
   logic [1:0] m_sel;

   always #5 clk = ~clk;

   reconfig_ctrl #(
      .CNT_W        (24),
      .TIMEOUT      (24'(TMO)),
      .SEL_W        (2),
      .AUTO_IMG     (AUTO_IMG),
      .FALLBACK_IMG (FALLBACK_IMG),
      .SETUP_CYC    (SETUP_CYC)
   ) dut (
      .clk            (clk),
      .rstn           (rstn),
      .auto_en        (auto_en),
      .req            (req),
      .req_img        (req_img),
      .cfg_ERROR      (cfg_ERROR),
      .cfg_CBSEL      (cfg_CBSEL),
      .cfg_ENA        (cfg_ENA),
      .cfg_CONFIG     (cfg_CONFIG),
      .cfg_ERROR_port (cfg_ERROR_port),
      .busy           (busy),
      .err_sticky     (err_sticky)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_ena = 0; m_busy = 0; m_cfg = 0; m_sticky = 0; m_counting = 0;
      m_retry = 0; m_timer = 0; m_arm_left = 0; m_sel = AUTO_IMG;
   endtask

   task automatic model_launch(input logic [1:0] img);
      m_sel = img; m_sticky = 0; m_busy = 1; m_counting = 0; m_timer = 0;
      m_arm_left = SETUP_CYC; m_retry = 0;
   endtask

   task automatic model_step(input bit a, input bit r, input logic [1:0] img, input bit e);
      if (!m_ena) begin
         m_ena = 1;
         return;
      end
      if (!m_busy) begin
         if (r) model_launch(img);
         else if (m_counting && !a) begin m_counting = 0; m_timer = 0; end
         else if (m_counting && m_timer == TMO) model_launch(AUTO_IMG);
         else if (m_counting) m_timer = (m_timer < TMO) ? m_timer + 1 : m_timer;
         else if (a) begin m_counting = 1; m_timer = 0; end
      end else if (m_arm_left > 0) begin
         m_arm_left--;
         if (m_arm_left == 0) m_cfg = 1;
      end else if (m_cfg) begin
         if (e) begin m_cfg = 0; m_sticky = 1; end
      end else begin
         // one-cycle error phase
`ifdef RECONFIG_RETRY_EN
         if (!m_retry && m_sel != FALLBACK_IMG) begin
            m_retry = 1; m_sel = FALLBACK_IMG; m_arm_left = SETUP_CYC;
         end else m_busy = 0;
`else
         m_busy = 0;
`endif
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_cfg_CONFIG"}, cfg_CONFIG, 0);
      chk({tag, "_cfg_ENA"},    cfg_ENA,    0);
      chk({tag, "_busy"},       busy,       0);
      chk({tag, "_err_sticky"}, err_sticky, 0);
      chk({tag, "_cfg_CBSEL"},  cfg_CBSEL,  AUTO_IMG);
   endtask

   // One clock: drive inputs, let the edge happen, step the model, compare.
   task automatic cycle(input bit a, input bit r, input logic [1:0] img, input bit e);
      auto_en = a; req = r; req_img = img; cfg_ERROR = e;
      #1;
      chk("err_passthru", cfg_ERROR_port, e);
      @(posedge clk);
      model_step(a, r, img, e);
      #1;
      chk("m_cfg_ENA",    cfg_ENA,    m_ena);
      chk("m_busy",       busy,       m_busy);
      chk("m_cfg_CONFIG", cfg_CONFIG, m_cfg);
      chk("m_cfg_CBSEL",  cfg_CBSEL,  m_sel);
      chk("m_err_sticky", err_sticky, m_sticky);
   endtask

   // Called just after a rising edge; checks outputs before any further edge.
   task automatic pulse_reset();
      rstn = 1'b0;
      #2;
      chk_reset("async_rst");
      model_reset();
      @(posedge clk);
      #1;
      rstn = 1'b1;
   endtask

   task automatic wait_fire(input string tag, input int exp_cycles);
      int n;
      n = 0;
      while (cfg_CONFIG !== 1'b1 && n < 20) begin
         cycle(0, 0, 2'b00, 0);
         n++;
      end
      chk(tag, n, exp_cycles);
   endtask

   initial begin
      int n;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk_reset("por");
      rstn = 1'b1;

      // Auto reconfiguration from reset
      n = 0;
      while (busy !== 1'b1 && n < 40) begin cycle(1, 0, 2'b00, 0); n++; end
      chk("auto_arm_latency", n, 13);
      chk("auto_img", cfg_CBSEL, AUTO_IMG);
      wait_fire("auto_fire_latency", SETUP_CYC);

      // Error while firing
      cycle(0, 0, 2'b00, 1);
      chk("err_cfg_drop", cfg_CONFIG, 0);
      chk("err_sticky_set", err_sticky, 1);
      cycle(0, 0, 2'b00, 0);
`ifdef RECONFIG_RETRY_EN
      chk("retry_busy", busy, 1);
      chk("retry_img", cfg_CBSEL, FALLBACK_IMG);
      wait_fire("retry_fire", SETUP_CYC);
      cycle(0, 0, 2'b00, 1);
      cycle(0, 0, 2'b00, 0);
`endif
      chk("err_to_idle", busy, 0);
      chk("sticky_held", err_sticky, 1);
      cycle(0, 1, 2'b10, 0);
      chk("req_clears_sticky", err_sticky, 0);
      chk("req_img", cfg_CBSEL, 2'b10);
      chk("req_busy", busy, 1);
      cycle(0, 1, 2'b01, 0);
      chk("busy_req_ignored", cfg_CBSEL, 2'b10);
      wait_fire("req_fire", SETUP_CYC - 1);
      chk("fire_before_reset", cfg_CONFIG, 1);
      pulse_reset();

      // First edge after release must not change state
      cycle(0, 1, 2'b01, 0);
      chk("first_edge_hold", busy, 0);

      // Request collides with timer expiry
      cycle(1, 0, 2'b00, 0);
      repeat (TMO) cycle(1, 0, 2'b00, 0);
      chk("pre_expiry_idle", busy, 0);
      cycle(1, 1, 2'b10, 0);
      chk("req_beats_expiry", cfg_CBSEL, 2'b10);
      chk("collide_busy", busy, 1);
      wait_fire("collide_fire", SETUP_CYC);
      chk("collide_img_held", cfg_CBSEL, 2'b10);
      pulse_reset();

      // User image 01 with errors
      cycle(0, 0, 2'b00, 0);
      cycle(0, 1, 2'b01, 0);
      chk("img1_sel", cfg_CBSEL, 2'b01);
      wait_fire("img1_fire", SETUP_CYC);
      cycle(0, 0, 2'b00, 1);
      cycle(0, 0, 2'b00, 0);
`ifdef RECONFIG_RETRY_EN
      chk("img1_retry_sel", cfg_CBSEL, 2'b00);
      chk("img1_retry_sticky", err_sticky, 1);
      wait_fire("img1_retry_fire", SETUP_CYC);
      cycle(0, 0, 2'b00, 1);
      chk("img1_err2_cfg", cfg_CONFIG, 0);
      cycle(0, 0, 2'b00, 0);
      chk("img1_final_sel", cfg_CBSEL, 2'b00);
`else
      chk("img1_final_sel", cfg_CBSEL, 2'b01);
`endif
      chk("img1_idle", busy, 0);
      chk("img1_sticky", err_sticky, 1);
      cycle(0, 0, 2'b00, 1);
      chk("idle_err_ignored", busy, 0);
      chk("idle_err_sticky", err_sticky, 1);

      // auto_en dropped at timer = 5, then re-enabled
      cycle(1, 0, 2'b00, 0);
      repeat (5) cycle(1, 0, 2'b00, 0);
      cycle(0, 0, 2'b00, 0);
      n = 0;
      while (busy !== 1'b1 && n < 40) begin cycle(1, 0, 2'b00, 0); n++; end
      chk("restart_latency", n, 12);
      chk("expiry_clears_sticky", err_sticky, 0);
      pulse_reset();

      // Randomized traffic
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 149) == 0) pulse_reset();
         else cycle($urandom_range(0, 7) != 0, $urandom_range(0, 19) == 0,
                    2'($urandom), $urandom_range(0, 4) == 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
